// File: rtl/multi_bit_fifo_rd.sv
// Synchronous circular-buffer FIFO with a registered read port,
// occupancy reporting and sticky overflow/underflow flags.
module multi_bit_fifo_rd #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] cnt;
  logic          full_w, empty_w;
  logic          rd_ok, wr_ok;

  // Occupancy comes from the registered pointers only.
  assign cnt     = wr_ptr_q - rd_ptr_q;
  assign full_w  = (cnt == PW'(DEPTH));
  assign empty_w = (cnt == '0);

  always_comb begin
    rd_ok    = rd & ~empty_w;
    wr_ok    = wr & (~full_w | rd_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (rd_ok) begin
      dout_d   = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d = rd_ptr_q + 1'b1;
      valid_d  = 1'b1;
    end else if (rd) begin
      unf_d = 1'b1;
    end
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else if (wr) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = cnt;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_multi_bit_fifo_rd.sv
// Directed scoreboard bench for multi_bit_fifo_rd.
// A queue models FIFO contents; popped words feed an output scoreboard.
module tb_multi_bit_fifo_rd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = '0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       valid, full, empty, overflow, underflow;
  logic [2:0] count;

  multi_bit_fifo_rd #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .din(din), .wr(wr), .rd(rd),
    .dout(dout), .valid(valid), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] e_dout = '0;
  logic       e_valid = 1'b0;
  logic       e_ovf = 1'b0;
  logic       e_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(valid), 32'(e_valid));
    chk({tag, ".dout"}, 32'(dout), 32'(e_dout));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == 4));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(e_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    e_dout = '0;
    e_valid = 1'b0;
    e_ovf = 1'b0;
    e_unf = 1'b0;
  endtask

  task automatic step(input string tag, input logic w, input logic r,
                      input logic [7:0] d);
    logic rok, wok;
    rok = r && (mq.size() > 0);
    wok = w && ((mq.size() < 4) || rok);
    if (rok) sb.push_back(mq.pop_front());
    if (wok) mq.push_back(d);
    if (w && !wok) e_ovf = 1'b1;
    if (r && !rok) e_unf = 1'b1;
    e_valid = rok;
    wr = w;
    rd = r;
    din = d;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    if (e_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL %s.sb: scoreboard empty", tag);
      end else begin
        e_dout = sb.pop_front();
      end
    end
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b0;
    step("idle", 0, 0, 8'h00);

    step("w11", 1, 0, 8'h11);
    step("w22", 1, 0, 8'h22);
    step("w33", 1, 0, 8'h33);
    step("w44", 1, 0, 8'h44);
    for (int i = 0; i < 4; i++) step("rd4", 0, 1, 8'h00);

    step("f11", 1, 0, 8'h11);
    step("f22", 1, 0, 8'h22);
    step("f33", 1, 0, 8'h33);
    step("f44", 1, 0, 8'h44);
    step("ovf55", 1, 0, 8'h55);
    for (int i = 0; i < 4; i++) step("drn_ovf", 0, 1, 8'h00);

    step("g11", 1, 0, 8'h11);
    step("g22", 1, 0, 8'h22);
    step("g33", 1, 0, 8'h33);
    step("g44", 1, 0, 8'h44);
    step("full_rw66", 1, 1, 8'h66);
    for (int i = 0; i < 4; i++) step("drn_rw", 0, 1, 8'h00);

    step("empty_rw77", 1, 1, 8'h77);
    step("rd77", 0, 1, 8'h00);

    step("pre_a0", 1, 0, 8'hA0);
    step("pre_a1", 1, 0, 8'hA1);
    for (int i = 0; i < 10; i++) step("wrap", 1, 1, 8'(8'hB0 + i));

    #1;
    reset = 1'b1;
    model_reset();
    #2;
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_idle", 0, 0, 8'h00);
    step("post_wC3", 1, 0, 8'hC3);
    step("post_rd", 0, 1, 8'h00);
    step("post_unf", 0, 1, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_bit_fifo_rd.md
Name: multi_bit_fifo_rd

Overview:
Multi-entry synchronous FIFO that adds the read side to the team's write-only multi-bit buffer. A producer pushes with `wr`; a consumer pops with `rd`. Popped data is returned on a registered `dout`, qualified by a one-cycle `valid` pulse. Sits between a producer datapath and a consumer stage in the same clock domain, and reports occupancy plus sticky error flags.

Parameters:
- DATA_WIDTH, 8, width of each data word.
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  write data, sampled when `wr` = 1.
- wr  input  1  push request.
- rd  input  1  pop request.
- dout  output  DATA_WIDTH  registered read data.
- valid  output  1  high for one cycle when `dout` holds a newly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- overflow  output  1  sticky; set by a dropped write.
- underflow  output  1  sticky; set by a rejected read.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately and holds while high):
  - dout=0, valid=0, full=0, empty=1, count=0, overflow=0, underflow=0.
  - Read and write pointers = 0.
  - Memory contents are not reset; they are unobservable until written.
- Storage: circular buffer of DEPTH words.
  - wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits and wrap naturally.
  - count = wr_ptr − rd_ptr, modulo 2^($clog2(DEPTH)+1).
  - full, empty and count are derived from the registered pointers only; there is no combinational path from `wr` or `rd`.
- Read acceptance: rd_ok = rd & !empty.
  - On rd_ok: dout <= mem[rd_ptr]; rd_ptr++; valid <= 1.
  - Otherwise valid <= 0 and dout holds its previous value.
  - Read latency is 1 clock: data appears on the edge that accepts the pop.
- Write acceptance: wr_ok = wr & (!full | rd_ok).
  - On wr_ok: mem[wr_ptr] <= din; wr_ptr++.
- Full with simultaneous rd and wr:
  - Both are accepted and count is unchanged.
  - dout gets the oldest entry; din goes to the freed slot.
- Empty with simultaneous rd and wr:
  - No bypass. The write is accepted (count becomes 1).
  - The read is rejected: underflow is set, valid=0.
- Nonzero and not full, with simultaneous rd and wr: both are accepted and count is unchanged.
- Rejected operations:
  - wr while full without rd_ok: data is dropped, pointers are unchanged, overflow <= 1.
  - rd while empty: underflow <= 1, dout holds, valid=0.
- Sticky flags: overflow and underflow clear only on reset.
- Ordering: strict FIFO; words pop in the order they were written, across pointer wrap-around.
- Reset mid-operation: all in-flight state is discarded. The next cycle after reset deasserts, the block behaves as freshly empty.
- No state machine beyond the pointer pair; every output is a flop or a pure function of flops.

Test Plan (DATA_WIDTH=8, DEPTH=4):
- Reset, then idle → dout=0, valid=0, empty=1, full=0, count=0, both flags 0.
- Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → count 1, 2, 3, 4; full=1 after the 4th edge. Then rd for 4 cycles → dout 0x11, 0x22, 0x33, 0x44 with valid=1 on each; empty=1 and count=0 at the end.
- Fill to full, then wr with din=0x55 and no rd → overflow=1, count stays 4. Subsequent 4 reads return 0x11..0x44 and never 0x55.
- Full, then one cycle of wr=1 (0x66) with rd=1 → dout=0x11, valid=1, count stays 4. Draining returns 0x22, 0x33, 0x44, 0x66.
- Empty, then one cycle of rd=1 with wr=1 (0x77) → underflow=1, valid=0, dout unchanged, count=1. The next rd returns 0x77.
- Run 10 write/read pairs with 2 entries resident so the pointers wrap twice → output order matches input order. Assert reset mid-stream → all outputs return to reset values immediately (asynchronously), including both cleared flags.
